// File: rtl/bless_age_alloc.sv
// Age-ordered BLESS switch allocator: ranks incoming flits oldest-first, gives each
// admitted flit one output (productive or deflected) and re-times control words.
module bless_age_alloc #(
  parameter int X_W   = 4,
  parameter int Y_W   = 4,
  parameter int AGE_W = 8,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [X_W+Y_W+AGE_W:0]     ctl0_in,
  input  logic [X_W+Y_W+AGE_W:0]     ctl1_in,
  input  logic [X_W+Y_W+AGE_W:0]     ctl2_in,
  input  logic [X_W+Y_W+AGE_W:0]     ctl3_in,
  input  logic [X_W+Y_W+AGE_W:0]     ctl4_in,
  output logic                       inj_ready,
  output logic [14:0]                route_config,
  output logic [X_W+Y_W+AGE_W:0]     ctl0_out,
  output logic [X_W+Y_W+AGE_W:0]     ctl1_out,
  output logic [X_W+Y_W+AGE_W:0]     ctl2_out,
  output logic [X_W+Y_W+AGE_W:0]     ctl3_out,
  output logic [X_W+Y_W+AGE_W:0]     ctl4_out,
  output logic [CNT_W-1:0]           deflect_cnt
);

  localparam int W = 1 + X_W + Y_W + AGE_W;
  localparam logic [2:0]     IDLE = 3'b111;
  localparam logic [X_W-1:0] HX   = X_W'(MY_X);
  localparam logic [Y_W-1:0] HY   = Y_W'(MY_Y);
  // Productive preference order: East, West, North, South
  localparam logic [2:0]     PREF [4] = '{3'd2, 3'd3, 3'd0, 3'd1};

  logic [W-1:0]     in_w   [5];
  logic [W-1:0]     in_q   [5];
  logic [W-1:0]     nxt_out[5];
  logic [W-1:0]     out_q  [5];
  logic [4:0]       valid;
  logic [4:0]       adm;
  logic [2:0]       rank   [5];
  logic [2:0]       sel    [5];
  logic [4:0]       used;
  logic [2:0]       defl_n;
  logic [X_W-1:0]   dx;
  logic [Y_W-1:0]   dy;
  logic [3:0]       prod;
  logic             placed;

  assign in_w[0] = ctl0_in;
  assign in_w[1] = ctl1_in;
  assign in_w[2] = ctl2_in;
  assign in_w[3] = ctl3_in;
  assign in_w[4] = ctl4_in;

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) valid[i] = in_w[i][W-1];
  end

  assign inj_ready = ~&valid[3:0];
  assign adm       = {valid[4] & inj_ready, valid[3:0]};

  // Rank = number of admitted flits that must be served before this one
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < 5; j++) begin
        if (adm[j] && (j != i) &&
            ((in_w[j][AGE_W-1:0] > in_w[i][AGE_W-1:0]) ||
             ((in_w[j][AGE_W-1:0] == in_w[i][AGE_W-1:0]) && (j < i))))
          rank[i] = rank[i] + 3'd1;
      end
    end
  end

  always_comb begin
    used   = '0;
    defl_n = '0;
    dx     = '0;
    dy     = '0;
    prod   = '0;
    placed = 1'b0;
    for (int unsigned o = 0; o < 5; o++) sel[o] = IDLE;
    for (int unsigned r = 0; r < 5; r++) begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (adm[i] && (rank[i] == 3'(r))) begin
          dx     = in_w[i][W-2 -: X_W];
          dy     = in_w[i][AGE_W+Y_W-1 -: Y_W];
          prod   = {dy < HY, dy > HY, dx < HX, dx > HX};
          placed = 1'b0;
          if ((dx == HX) && (dy == HY)) begin
            if (!used[4]) begin
              used[4] = 1'b1;
              sel[4]  = 3'(i);
              placed  = 1'b1;
            end
          end else begin
            for (int unsigned k = 0; k < 4; k++) begin
              if (!placed && prod[k] && !used[PREF[k]]) begin
                used[PREF[k]] = 1'b1;
                sel[PREF[k]]  = 3'(i);
                placed        = 1'b1;
              end
            end
          end
          // Deflection never targets the local port
          for (int unsigned o = 0; o < 4; o++) begin
            if (!placed && !used[o]) begin
              used[o] = 1'b1;
              sel[o]  = 3'(i);
              placed  = 1'b1;
              defl_n  = defl_n + 3'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_config <= 15'h7FFF;
      deflect_cnt  <= '0;
      for (int unsigned i = 0; i < 5; i++) in_q[i] <= '0;
    end else begin
      for (int unsigned o = 0; o < 5; o++) route_config[3*o +: 3] <= sel[o];
      for (int unsigned i = 0; i < 5; i++) in_q[i] <= in_w[i];
      deflect_cnt <= deflect_cnt + CNT_W'(defl_n);
    end
  end

  // Second stage: outgoing control words follow the registered route, age saturating
  always_comb begin
    for (int unsigned o = 0; o < 5; o++) begin
      nxt_out[o] = '0;
      if (route_config[3*o +: 3] <= 3'd4) begin
        nxt_out[o] = in_q[route_config[3*o +: 3]];
        if (nxt_out[o][AGE_W-1:0] != '1)
          nxt_out[o][AGE_W-1:0] = nxt_out[o][AGE_W-1:0] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < 5; o++) out_q[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < 5; o++) out_q[o] <= nxt_out[o];
    end
  end

  assign ctl0_out = out_q[0];
  assign ctl1_out = out_q[1];
  assign ctl2_out = out_q[2];
  assign ctl3_out = out_q[3];
  assign ctl4_out = out_q[4];

endmodule

// File: tb/tb_bless_age_alloc.sv
// Randomized and directed check of bless_age_alloc against a behavioural allocation model.
module tb_bless_age_alloc;
  localparam int XW = 4, YW = 4, AW = 8, CW = 2, W = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_w [5];
  logic          inj_ready;
  logic [14:0]   route_config;
  logic [W-1:0]  out_w [5];
  logic [CW-1:0] deflect_cnt;

  bless_age_alloc #(.X_W(XW), .Y_W(YW), .AGE_W(AW), .MY_X(2), .MY_Y(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ctl0_in(in_w[0]), .ctl1_in(in_w[1]), .ctl2_in(in_w[2]), .ctl3_in(in_w[3]), .ctl4_in(in_w[4]),
    .inj_ready(inj_ready), .route_config(route_config),
    .ctl0_out(out_w[0]), .ctl1_out(out_w[1]), .ctl2_out(out_w[2]), .ctl3_out(out_w[3]),
    .ctl4_out(out_w[4]), .deflect_cnt(deflect_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [14:0]  m_rc;
  logic [W-1:0] m_ctl [5];
  logic [W-1:0] m_pw  [5];
  int           m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int x, input int y, input int a);
    return {1'b1, 4'(x), 4'(y), 8'(a)};
  endfunction

  task automatic idle();
    for (int i = 0; i < 5; i++) in_w[i] = '0;
  endtask

  task automatic model_reset();
    m_rc  = 15'h7FFF;
    m_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      m_ctl[i] = '0;
      m_pw[i]  = '0;
    end
  endtask

  task automatic model_alloc(output logic [14:0] rc, output int nd);
    int owner [5];
    bit adm [5];
    bit done [5];
    int best, dx, dy;
    int pref [$];
    bit placed, rdy;
    rdy = !(in_w[0][16] && in_w[1][16] && in_w[2][16] && in_w[3][16]);
    nd  = 0;
    for (int i = 0; i < 5; i++) begin
      owner[i] = -1;
      done[i]  = 0;
      adm[i]   = (i < 4) ? in_w[i][16] : (in_w[4][16] && rdy);
    end
    repeat (5) begin
      best = -1;
      for (int i = 0; i < 5; i++)
        if (adm[i] && !done[i] && (best < 0 || in_w[i][7:0] > in_w[best][7:0])) best = i;
      if (best < 0) break;
      done[best] = 1;
      dx = int'(in_w[best][15:12]);
      dy = int'(in_w[best][11:8]);
      placed = 0;
      if (dx == 2 && dy == 2) begin
        if (owner[4] < 0) begin owner[4] = best; placed = 1; end
      end else begin
        pref.delete();
        if (dx > 2) pref.push_back(2);
        if (dx < 2) pref.push_back(3);
        if (dy > 2) pref.push_back(0);
        if (dy < 2) pref.push_back(1);
        foreach (pref[k])
          if (!placed && owner[pref[k]] < 0) begin owner[pref[k]] = best; placed = 1; end
      end
      for (int o = 0; o < 4; o++)
        if (!placed && owner[o] < 0) begin owner[o] = best; placed = 1; nd++; end
    end
    for (int o = 0; o < 5; o++) rc[3*o +: 3] = (owner[o] < 0) ? 3'b111 : 3'(owner[o]);
  endtask

  task automatic model_edge();
    logic [14:0] rc;
    int nd;
    logic [2:0] s;
    logic [7:0] a;
    for (int o = 0; o < 5; o++) begin
      s = m_rc[3*o +: 3];
      if (s == 3'b111) m_ctl[o] = '0;
      else begin
        a = m_pw[s][7:0];
        m_ctl[o] = {m_pw[s][16:8], (a == 8'hFF) ? a : 8'(a + 8'd1)};
      end
    end
    model_alloc(rc, nd);
    m_rc = rc;
    for (int i = 0; i < 5; i++) m_pw[i] = in_w[i];
    m_cnt = (m_cnt + nd) % 4;
  endtask

  task automatic check_all();
    chk("route_config", 32'(route_config), 32'(m_rc));
    for (int o = 0; o < 5; o++) chk($sformatf("ctl%0d_out", o), 32'(out_w[o]), 32'(m_ctl[o]));
    chk("deflect_cnt", 32'(deflect_cnt), 32'(m_cnt));
    chk("inj_ready", 32'(inj_ready),
        32'(!(in_w[0][16] && in_w[1][16] && in_w[2][16] && in_w[3][16])));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_route", 32'(route_config), 32'h7FFF);
    chk("rst_cnt", 32'(deflect_cnt), 32'h0);
    chk("rst_ctl2", 32'(out_w[2]), 32'h0);
    #2 rst = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    chk("init_route", 32'(route_config), 32'h7FFF);
    @(negedge clk);
    rst = 1'b0;

    // single flit heading East
    in_w[1] = mk(5, 2, 3);
    step();
    chk("single_route", 32'(route_config), 32'h7E7F);
    chk("single_cnt", 32'(deflect_cnt), 32'h0);
    idle();
    step();
    chk("single_ctl2", 32'(out_w[2]), 32'(mk(5, 2, 4)));

    // older flit wins East, younger deflects to North
    in_w[0] = mk(5, 2, 9);
    in_w[3] = mk(5, 2, 4);
    step();
    chk("conflict_route", 32'(route_config), 32'h7E3B);
    chk("conflict_cnt", 32'(deflect_cnt), 32'h1);
    idle();
    step();
    chk("conflict_ctl2", 32'(out_w[2]), 32'(mk(5, 2, 10)));
    chk("conflict_ctl0", 32'(out_w[0]), 32'(mk(5, 2, 5)));

    // equal ages ejecting: lower index ejects
    in_w[1] = mk(2, 2, 7);
    in_w[2] = mk(2, 2, 7);
    step();
    chk("eject_route", 32'(route_config), 32'h1FFA);
    chk("eject_cnt", 32'(deflect_cnt), 32'h2);
    idle();
    step();
    chk("eject_ctl4", 32'(out_w[4]), 32'(mk(2, 2, 8)));
    chk("eject_ctl0", 32'(out_w[0]), 32'(mk(2, 2, 8)));

    // age saturation
    in_w[1] = mk(5, 2, 255);
    step();
    idle();
    step();
    chk("sat_ctl2", 32'(out_w[2]), 32'(mk(5, 2, 255)));

    // counter wrap with 2-bit width
    in_w[0] = mk(5, 2, 9);
    in_w[3] = mk(5, 2, 4);
    step();
    chk("wrap_cnt3", 32'(deflect_cnt), 32'h3);
    step();
    chk("wrap_cnt0", 32'(deflect_cnt), 32'h0);
    idle();
    step();

    // injection gating
    in_w[0] = mk(0, 2, 50);
    in_w[1] = mk(2, 0, 40);
    in_w[2] = mk(2, 2, 30);
    in_w[3] = mk(5, 5, 20);
    in_w[4] = mk(5, 5, 200);
    #1 chk("inj_blocked", 32'(inj_ready), 32'h0);
    step();
    for (int o = 0; o < 5; o++)
      chk($sformatf("no_inject_out%0d", o), 32'(route_config[3*o +: 3] == 3'd4), 32'h0);
    in_w[3] = '0;
    #1 chk("inj_open", 32'(inj_ready), 32'h1);
    step();
    chk("inj_east", 32'(route_config[8:6]), 32'h4);

    // asynchronous reset with traffic in flight, then normal routing
    in_w[0] = mk(5, 2, 9);
    in_w[3] = mk(5, 2, 4);
    step();
    mid_reset();
    idle();
    in_w[1] = mk(5, 2, 3);
    step();
    chk("post_rst_route", 32'(route_config), 32'h7E7F);
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) mid_reset();
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 3))
            0:       in_w[i] = mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 255));
            1:       in_w[i] = mk($urandom_range(0, 4), $urandom_range(0, 4), 254 + $urandom_range(0, 1));
            default: in_w[i] = mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(10, 12));
          endcase
        end else begin
          in_w[i] = '0;
        end
      end
      step();
    end
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
